instr_trace_monitor: RTL and testbench

- Synthesisable, parametrised successor to the pipeline bench's PC/instruction printout; sits beside mips_pipeline and taps the retire point (PC, opcode, funct, register-file write data).
- Classifies each sampled instruction, keeps per-class saturating counters plus an enabled-cycle counter, and buffers selected records in a show-ahead trace FIFO.
- The FIFO is drained over a valid/ready handshake, so traces survive on silicon/FPGA without $display.

---
 rtl/instr_trace_monitor.sv | 159 +++++++++++++++
 tb/tb_instr_trace_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_trace_monitor.sv
// Retire-point instruction monitor: classifies sampled instructions, keeps
// saturating per-class statistics and buffers selected records in a show-ahead FIFO.
module instr_trace_monitor #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pc_enable,
    input  logic                             smp_valid,
    input  logic [PC_WIDTH-1:0]              smp_pc,
    input  logic [5:0]                       smp_opcode,
    input  logic [5:0]                       smp_funct,
    input  logic [DATA_WIDTH-1:0]            smp_wd,
    input  logic [8:0]                       class_mask,
    input  logic                             clear,
    output logic                             trace_valid,
    input  logic                             trace_ready,
    output logic [4+PC_WIDTH+DATA_WIDTH-1:0] trace_data,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             overflow,
    output logic [CNT_WIDTH-1:0]             drop_cnt,
    input  logic [3:0]                       cnt_sel,
    output logic [CNT_WIDTH-1:0]             cnt_data
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TW   = 4 + PC_WIDTH + DATA_WIDTH;
    localparam int NCNT = 10;

    function automatic logic [3:0] classify(input logic [5:0] opcode, input logic [5:0] funct);
        logic [3:0] c;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd32:   c = 4'd0;
                    6'd34:   c = 4'd1;
                    6'd36:   c = 4'd2;
                    6'd37:   c = 4'd3;
                    default: c = 4'd8;
                endcase
            end
            6'd35:   c = 4'd4;
            6'd43:   c = 4'd5;
            6'd4:    c = 4'd6;
            6'd2:    c = 4'd7;
            default: c = 4'd8;
        endcase
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] cnt_r [NCNT];
    logic [TW-1:0]        mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          level_r;
    logic                 overflow_r;
    logic [CNT_WIDTH-1:0] drop_cnt_r;

    logic                 sample_s;
    logic [3:0]           class_s;
    logic                 log_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic [TW-1:0]        record_s;
    logic [CNT_WIDTH-1:0] cnt_data_s;

    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign sample_s = smp_valid & pc_enable & ~clear;
    assign class_s  = classify(smp_opcode, smp_funct);
    assign log_s    = sample_s & class_mask[class_s];
    assign full_s   = (level_r == (AW+1)'(FIFO_DEPTH));
    assign pop_s    = trace_valid & trace_ready & ~clear;
    assign push_s   = log_s & (~full_s | pop_s);
    assign drop_s   = log_s & full_s & ~pop_s;
    assign record_s = {class_s, smp_pc, smp_wd};

    assign trace_valid = (level_r != {(AW+1){1'b0}});
    assign trace_data  = trace_valid ? mem_r[rd_ptr_r] : {TW{1'b0}};
    assign fifo_level  = level_r;
    assign overflow    = overflow_r;
    assign drop_cnt    = drop_cnt_r;
    assign cnt_data    = cnt_data_s;

    // Statistics counters: per-class sample counts plus the enabled-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCNT; k++) cnt_r[k] <= {CNT_WIDTH{1'b0}};
        end else if (clear) begin
            for (int k = 0; k < NCNT; k++) cnt_r[k] <= {CNT_WIDTH{1'b0}};
        end else begin
            for (int k = 0; k < NCNT - 1; k++) begin
                if (sample_s && (class_s == 4'(k))) cnt_r[k] <= sat_inc(cnt_r[k]);
            end
            if (pc_enable) cnt_r[NCNT-1] <= sat_inc(cnt_r[NCNT-1]);
        end
    end

    // FIFO pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (clear) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    // Trace storage; contents are only observable through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= record_s;
    end

    // Counter read mux.
    always_comb begin
        cnt_data_s = {CNT_WIDTH{1'b0}};
        case (cnt_sel)
            4'd0:    cnt_data_s = cnt_r[0];
            4'd1:    cnt_data_s = cnt_r[1];
            4'd2:    cnt_data_s = cnt_r[2];
            4'd3:    cnt_data_s = cnt_r[3];
            4'd4:    cnt_data_s = cnt_r[4];
            4'd5:    cnt_data_s = cnt_r[5];
            4'd6:    cnt_data_s = cnt_r[6];
            4'd7:    cnt_data_s = cnt_r[7];
            4'd8:    cnt_data_s = cnt_r[8];
            4'd9:    cnt_data_s = cnt_r[9];
            default: cnt_data_s = {CNT_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_instr_trace_monitor.sv
// Scoreboard bench for instr_trace_monitor: a full-width instance and a
// CNT_WIDTH=4 instance share stimulus; a bench model predicts counters and FIFO traffic.
module tb_instr_trace_monitor;

    typedef logic [67:0] rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_enable;
    logic        smp_valid;
    logic [31:0] smp_pc;
    logic [5:0]  smp_opcode;
    logic [5:0]  smp_funct;
    logic [31:0] smp_wd;
    logic [8:0]  class_mask;
    logic        clear;
    logic        trace_ready;
    logic [3:0]  cnt_sel;

    logic        trace_valid;
    rec_t        trace_data;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [31:0] drop_cnt;
    logic [31:0] cnt_data;

    logic        s_trace_valid;
    rec_t        s_trace_data;
    logic [4:0]  s_fifo_level;
    logic        s_overflow;
    logic [3:0]  s_drop_cnt;
    logic [3:0]  s_cnt_data;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mcnt [10];
    int   mdrop;
    bit   movf;
    rec_t q [$];

    instr_trace_monitor #(.PC_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .pc_enable(pc_enable), .smp_valid(smp_valid), .smp_pc(smp_pc),
        .smp_opcode(smp_opcode), .smp_funct(smp_funct), .smp_wd(smp_wd), .class_mask(class_mask),
        .clear(clear), .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt), .cnt_sel(cnt_sel),
        .cnt_data(cnt_data)
    );

    instr_trace_monitor #(.PC_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4), .FIFO_DEPTH(16)) dut_small (
        .clk(clk), .rst(rst), .pc_enable(pc_enable), .smp_valid(smp_valid), .smp_pc(smp_pc),
        .smp_opcode(smp_opcode), .smp_funct(smp_funct), .smp_wd(smp_wd), .class_mask(class_mask),
        .clear(clear), .trace_valid(s_trace_valid), .trace_ready(trace_ready), .trace_data(s_trace_data),
        .fifo_level(s_fifo_level), .overflow(s_overflow), .drop_cnt(s_drop_cnt), .cnt_sel(cnt_sel),
        .cnt_data(s_cnt_data)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cls(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'd32) return 4'd0;
            if (fn == 6'd34) return 4'd1;
            if (fn == 6'd36) return 4'd2;
            if (fn == 6'd37) return 4'd3;
            return 4'd8;
        end
        if (op == 6'd35) return 4'd4;
        if (op == 6'd43) return 4'd5;
        if (op == 6'd4)  return 4'd6;
        if (op == 6'd2)  return 4'd7;
        return 4'd8;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 10; k++) mcnt[k] = 0;
        mdrop = 0;
        movf  = 1'b0;
        q.delete();
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] pc, input logic [31:0] wd);
        smp_valid  = v;
        smp_opcode = op;
        smp_funct  = fn;
        smp_pc     = pc;
        smp_wd     = wd;
    endtask

    // One clock: predict this edge from current inputs, compare head on pop, then compare state.
    task automatic step();
        bit popped;
        bit full;
        logic [3:0] c;
        popped = 1'b0;
        if (clear) begin
            model_reset();
        end else begin
            full = (q.size() == 16);
            if (trace_ready && q.size() > 0) begin
                check("head_valid", 128'(trace_valid), 128'd1);
                check("head_data", 128'(trace_data), 128'(q[0]));
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (pc_enable) mcnt[9]++;
            if (smp_valid && pc_enable) begin
                c = cls(smp_opcode, smp_funct);
                mcnt[c]++;
                if (class_mask[c]) begin
                    if (!full || popped) q.push_back({c, smp_pc, smp_wd});
                    else begin
                        movf = 1'b1;
                        mdrop++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("fifo_level", 128'(fifo_level), 128'(q.size()));
        check("trace_valid", 128'(trace_valid), 128'(q.size() > 0));
        check("overflow", 128'(overflow), 128'(movf));
        check("drop_cnt", 128'(drop_cnt), 128'(mdrop));
    endtask

    task automatic check_counters();
        for (int k = 0; k < 12; k++) begin
            cnt_sel = 4'(k);
            #1;
            check($sformatf("cnt[%0d]", k), 128'(cnt_data), (k < 10) ? 128'(mcnt[k]) : 128'd0);
            check($sformatf("cnt4[%0d]", k), 128'(s_cnt_data),
                  (k < 10) ? 128'((mcnt[k] > 15) ? 15 : mcnt[k]) : 128'd0);
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        ops = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd13};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd8};

        rst = 1'b1; pc_enable = 1'b0; clear = 1'b0; trace_ready = 1'b0;
        class_mask = 9'h1FF; cnt_sel = 4'd0;
        drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", 128'(trace_valid), 128'd0);
        check("rst_level", 128'(fifo_level), 128'd0);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_data", 128'(trace_data), 128'd0);
        check_counters();

        // Single ADD with everything logged, visible one edge later.
        pc_enable = 1'b1;
        drive(1'b1, 6'd0, 6'd32, 32'h4, 32'd5);
        step();
        check("add_rec", 128'(trace_data), 128'({4'd0, 32'h4, 32'd5}));
        check_counters();
        drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;

        // LW masked out: counted, not logged.
        class_mask = 9'h1EF;
        drive(1'b1, 6'd35, 6'd0, 32'h8, 32'd9);
        step();
        check("lw_masked_valid", 128'(trace_valid), 128'd0);
        check_counters();

        // Fill past capacity with no consumer, then a push that coincides with a pop.
        class_mask = 9'h1FF;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 6'd0, 6'd32, 32'h100 + 32'(4 * i), 32'(i));
            step();
        end
        check("full_level", 128'(fifo_level), 128'd16);
        check("full_overflow", 128'(overflow), 128'd1);
        check("full_drop", 128'(drop_cnt), 128'd1);
        check_counters();
        trace_ready = 1'b1;
        drive(1'b1, 6'd0, 6'd32, 32'h200, 32'd77);
        step();
        check("pushpop_level", 128'(fifo_level), 128'd16);
        check("pushpop_drop", 128'(drop_cnt), 128'd1);
        drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) step();
        check("drained_level", 128'(fifo_level), 128'd0);

        // Saturation on the 4-bit instance.
        class_mask = 9'h000;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'd4, 6'd0, 32'h300 + 32'(4 * i), 32'd0);
            step();
        end
        cnt_sel = 4'd6;
        #1 check("beq_sat4", 128'(s_cnt_data), 128'd15);
        check_counters();

        // Clear races a J sample while three records are buffered.
        class_mask = 9'h1FF;
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd2, 6'd0, 32'h400 + 32'(4 * i), 32'd1);
            step();
        end
        clear = 1'b1;
        drive(1'b1, 6'd2, 6'd0, 32'h40C, 32'd1);
        step();
        clear = 1'b0;
        cnt_sel = 4'd7;
        #1 check("clear_cnt7", 128'(cnt_data), 128'd0);
        check_counters();

        // Randomised traffic, including disabled cycles that still drain.
        for (int i = 0; i < 200; i++) begin
            pc_enable   = ($urandom_range(0, 3) != 0);
            trace_ready = $urandom_range(0, 1);
            clear       = ($urandom_range(0, 39) == 0);
            class_mask  = 9'($urandom);
            drive(1'($urandom), ops[$urandom_range(0, 6)], fns[$urandom_range(0, 4)],
                  $urandom, $urandom);
            step();
        end
        clear = 1'b0;
        pc_enable = 1'b1;
        check_counters();

        // Asynchronous reset mid-operation.
        class_mask = 9'h1FF;
        trace_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'd43, 6'd0, 32'h500 + 32'(4 * i), 32'd3);
            step();
        end
        drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        check("async_level", 128'(fifo_level), 128'd0);
        check("async_valid", 128'(trace_valid), 128'd0);
        check("async_data", 128'(trace_data), 128'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        pc_enable = 1'b0;
        check_counters();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
